f2_d_fetch_queue: RTL and testbench

Parametrised fetch-to-decode pipeline buffer. It replaces the single-entry F2→D register with a DEPTH-entry FIFO that uses valid/ready handshakes. Fetch can run ahead of a stalled decode, and flush drops every buffered instruction. It sits between fetch stage 2 (instruction memory return) and the decode stage.

---
 rtl/risc_pkg.sv | 5 +
 rtl/fq_mem.sv | 26 ++
 rtl/f2_d_fetch_queue.sv | 74 +++++++
 tb/tb_f2_d_fetch_queue.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared RISC core constants used by the front-end pipeline blocks.
package risc_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
endpackage

// File: rtl/fq_mem.sv
// Register array for the fetch queue: synchronous write, combinational read.
module fq_mem #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wr_idx,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [AW-1:0]     rd_idx,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are don't-care after reset/flush, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/f2_d_fetch_queue.sv
// Fetch-to-decode FIFO with valid/ready handshakes; flush drops all buffered entries.
module f2_d_fetch_queue #(
    parameter int XLEN  = risc_pkg::XLEN,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   inst_in,
    input  logic [XLEN-1:0]   pc_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   inst_out,
    output logic [XLEN-1:0]   pc_out,
    output logic [CNT_W-1:0]  count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               push;
    logic               pop;
    logic [2*XLEN-1:0]  rd_data;

    // in_ready looks only at registered occupancy, never at out_ready.
    assign in_ready  = (cnt != CNT_W'(DEPTH));
    assign out_valid = (cnt != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign count     = cnt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    fq_mem #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we      (push && !rst),
        .wr_idx  (wr_ptr),
        .wr_data ({inst_in, pc_in}),
        .rd_idx  (rd_ptr),
        .rd_data (rd_data)
    );

    // An empty queue presents a legal bubble to decode.
    assign inst_out = out_valid ? rd_data[2*XLEN-1:XLEN] : XLEN'(risc_pkg::NOP_INST);
    assign pc_out   = out_valid ? rd_data[XLEN-1:0]      : '0;

endmodule

// File: tb/tb_f2_d_fetch_queue.sv
// Scoreboard bench for f2_d_fetch_queue: directed scenarios followed by random traffic.
module tb_f2_d_fetch_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [XLEN-1:0]   inst_in = '0;
    logic [XLEN-1:0]   pc_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [XLEN-1:0]   inst_out;
    logic [XLEN-1:0]   pc_out;
    logic [CNT_W-1:0]  count;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;
    int occ      = 0;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t sb[$];

    always #5 clk = ~clk;

    f2_d_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst_in   (inst_in),
        .pc_in     (pc_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst_out  (inst_out),
        .pc_out    (pc_out),
        .count     (count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected side: an accepted instruction joins the reference queue; reset and flush empty it.
    always @(posedge clk) begin
        if (rst || flush) begin
            sb.delete();
        end else if (in_valid && occ < DEPTH) begin
            sb.push_back('{inst: inst_in, pc: pc_in});
        end
    end

    // Monitor: compare what the DUT presents against the reference, retire on handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            occ = sb.size();
            chk("count", 64'(count), 64'(occ));
            chk("in_ready", 64'(in_ready), 64'(occ != DEPTH));
            chk("out_valid", 64'(out_valid), 64'(occ != 0));
            if (occ == 0) begin
                chk("bubble_inst", 64'(inst_out), 64'(NOP));
                chk("bubble_pc", 64'(pc_out), 64'd0);
            end else begin
                chk("head_inst", 64'(inst_out), 64'(sb[0].inst));
                chk("head_pc", 64'(pc_out), 64'(sb[0].pc));
                if (out_ready && !flush && !rst) begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic drive(input bit iv, input bit ordy, input bit fl, input bit r,
                         input logic [XLEN-1:0] pc);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        pc_in     = pc;
        inst_in   = {pc[15:0], ~pc[15:0]};
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held two cycles, then idle.
        drive(0, 0, 0, 1, '0);
        mon_en = 1'b1;
        drive(0, 0, 0, 1, '0);
        drive(0, 0, 0, 0, '0);
        drive(0, 1, 0, 0, '0);

        // Stall fill plus refused fifth push.
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 32'h100 + 32'(4 * i));
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_head", 64'(pc_out), 64'h100);
        // Pop from full: same-cycle push refused, accepted one cycle later.
        drive(1, 1, 0, 0, 32'h110);
        drive(1, 0, 0, 0, 32'h110);
        chk("refill_count", 64'(count), 64'd4);
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, '0);

        // Streaming across pointer wrap.
        for (int i = 0; i < 20; i++) drive(1, 1, 0, 0, 32'h1000 + 32'(4 * i));
        chk("stream_count", 64'(count), 64'd1);
        drive(0, 1, 0, 0, '0);

        // Flush collision at count 3.
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 32'h300 + 32'(4 * i));
        drive(1, 1, 1, 0, 32'h3FC);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_inst", 64'(inst_out), 64'(NOP));
        drive(0, 1, 0, 0, '0);

        // Reset mid-operation at count 2, then a clean push.
        for (int i = 0; i < 2; i++) drive(1, 0, 0, 0, 32'h400 + 32'(4 * i));
        drive(1, 1, 0, 1, 32'h4FC);
        chk("rst_count", 64'(count), 64'd0);
        drive(1, 0, 0, 0, 32'h500);
        chk("post_rst_pc", 64'(pc_out), 64'h500);
        drive(0, 1, 0, 0, '0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 60) == 0,
                  32'($urandom));
        end
        for (int i = 0; i < DEPTH + 1; i++) drive(0, 1, 0, 0, '0);
        chk("drained", 64'(count), 64'd0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
